add_share_arbiter: RTL

Round-robin scheduler that shares one W-bit adder among NREQ requesters. Each requester presents two operands and a request line; the block grants one requester at a time, latches its operands, computes the registered sum with carry-out, and returns the result tagged with the requester index. It sits between the per-client request logic in the top-level tile and the single shared adder datapath, so clients never drive the adder directly.

---
 rtl/add_share_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/add_share_arbiter.sv
// Round-robin scheduler sharing one W-bit adder among NREQ requesters.
// Grants one requester per operation, latches its operands and returns a registered sum tagged by index.
module add_share_arbiter #(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [NREQ-1:0] r_gnt;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_busy;

    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic [IDW:0]    w_sum_idx;
    logic [IDW:0]    w_cand;
    logic [IDW-1:0]  w_ptr_next;

    // Round-robin search: first requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        w_any     = 1'b0;
        w_win     = '0;
        w_sum_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            w_cand    = (w_sum_idx >= (IDW+1)'(NREQ)) ? (w_sum_idx - (IDW+1)'(NREQ)) : w_sum_idx;
            w_win     = (req[w_cand] && !w_any) ? w_cand[IDW-1:0] : w_win;
            w_any     = w_any | req[w_cand];
        end
        w_ptr_next = (w_win == IDW'(NREQ-1)) ? '0 : (w_win + IDW'(1));
    end

    // Operation sequencer: arbitrate in IDLE, add in CALC, present result in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (w_any) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_a     <= op_a[w_win*W +: W];
                        r_b     <= op_b[w_win*W +: W];
                        r_id    <= w_win;
                        r_ptr   <= w_ptr_next;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_gnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_state            <= S_RESP;
                    r_gnt              <= '0;
                    {r_carry, r_sum}   <= {1'b0, r_a} + {1'b0, r_b};
                    r_rsp_id           <= r_id;
                    r_rsp_valid        <= 1'b1;
                    r_busy             <= 1'b1;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_gnt       <= '0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_gnt       <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_sum;
    assign rsp_carry = r_carry;
    assign busy      = r_busy;

endmodule
